// File: rtl/dbus_pkg.sv
// Shared constants for the DBUS source arbiter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package dbus_pkg;

  // DBUS mux source selects (shared by microcode and console)
  localparam logic [1:0] SEL_FLAGS = 2'd0;
  localparam logic [1:0] SEL_DP    = 2'd1;
  localparam logic [1:0] SEL_RAM   = 2'd2;
  localparam logic [1:0] SEL_DBM   = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMWAIT = 3'd1,
    CONSEL  = 3'd2,
    CONRAM  = 3'd3,
    CONCAP  = 3'd4
  } state_t;

endpackage

// File: rtl/dbus_arb.sv
// DBUS source arbiter: microcode select with ramfile wait insertion, plus console snoop.
// Latency: console ack 3 cycles after grant sample (4 when sampling RAM); RAM wait adds 1 cycle.
// Backpressure: stalls the microsequencer via cpuWAIT; console request is a level, one ack per level.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cromDBUS_SEL          microcode DBUS source request
//   forceRAMFILE          turns a DBM request into RAM
//   cpuHALT               console access allowed only while set
//   conREQ, conSEL        console snoop request level and source
//   dbus                  DBUS mux output, sampled for the console
//   dbusSEL               select driven to the DBUS mux
//   cpuWAIT               stall the microsequencer this cycle
//   conACK, conDATA       one-cycle ack pulse and captured DBUS value
module dbus_arb
  import dbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  cromDBUS_SEL,
  input  logic        forceRAMFILE,
  input  logic        cpuHALT,
  input  logic        conREQ,
  input  logic [1:0]  conSEL,
  input  logic [35:0] dbus,
  output logic [1:0]  dbusSEL,
  output logic        cpuWAIT,
  output logic        conACK,
  output logic [35:0] conDATA
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] eff_sel;
  logic [1:0] prev_sel;
  logic       wait_c;
  logic       armed;

  always_comb begin
    eff_sel = cromDBUS_SEL;
    if (forceRAMFILE && (cromDBUS_SEL == SEL_DBM)) begin
      eff_sel = SEL_RAM;
    end
  end

  always_comb begin
    state_nxt = state;
    dbusSEL   = eff_sel;
    wait_c    = 1'b0;
    case (state)
      IDLE: begin
        dbusSEL = eff_sel;
        // The ramfile read is synchronous: a fresh switch onto RAM needs one extra cycle.
        if ((eff_sel == SEL_RAM) && (prev_sel != SEL_RAM)) begin
          wait_c    = 1'b1;
          state_nxt = RAMWAIT;
        end else if (cpuHALT && conREQ && armed) begin
          state_nxt = CONSEL;
        end
      end
      RAMWAIT: begin
        dbusSEL   = SEL_RAM;
        state_nxt = IDLE;
      end
      CONSEL: begin
        dbusSEL   = conSEL;
        wait_c    = 1'b1;
        state_nxt = (conSEL == SEL_RAM) ? CONRAM : CONCAP;
      end
      CONRAM: begin
        dbusSEL   = SEL_RAM;
        wait_c    = 1'b1;
        state_nxt = CONCAP;
      end
      CONCAP: begin
        dbusSEL   = conSEL;
        wait_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // During reset the IDLE select still reaches the mux, but the stall is held off.
  assign cpuWAIT = wait_c & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prev_sel <= SEL_DP;
      conACK   <= 1'b0;
      conDATA  <= '0;
      armed    <= 1'b1;
    end else begin
      state    <= state_nxt;
      prev_sel <= dbusSEL;
      conACK   <= (state == CONCAP);
      if (state == CONCAP) begin
        conDATA <= dbus;
      end
      // A low conREQ re-arms even on the capture edge: that level has already ended.
      if (!conREQ) begin
        armed <= 1'b1;
      end else if (state == CONCAP) begin
        armed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dbus_arb.sv
module tb_dbus_arb;
  import dbus_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  cromDBUS_SEL;
  logic        forceRAMFILE;
  logic        cpuHALT;
  logic        conREQ;
  logic [1:0]  conSEL;
  logic [35:0] dbus;
  logic [1:0]  dbusSEL;
  logic        cpuWAIT;
  logic        conACK;
  logic [35:0] conDATA;

  int n_cmp = 0;
  int n_err = 0;
  int n_ack = 0;
  int ack_base;
  logic [35:0] exp_q[$];
  logic [35:0] v;

  dbus_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cromDBUS_SEL (cromDBUS_SEL),
    .forceRAMFILE (forceRAMFILE),
    .cpuHALT      (cpuHALT),
    .conREQ       (conREQ),
    .conSEL       (conSEL),
    .dbus         (dbus),
    .dbusSEL      (dbusSEL),
    .cpuWAIT      (cpuWAIT),
    .conACK       (conACK),
    .conDATA      (conDATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: outputs are checked at the falling edge, inputs change 1 after the rising edge.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] sel, input logic w, input logic ack);
    settle();
    chk({tag, "_sel"}, 36'(dbusSEL), 36'(sel));
    chk({tag, "_wait"}, 36'(cpuWAIT), 36'(w));
    chk({tag, "_ack"}, 36'(conACK), 36'(ack));
  endtask

  // Scoreboard: every ack pops the value pushed when the request was driven.
  always @(negedge clk) begin
    if (rst_n && conACK) begin
      n_ack++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL unexpected_ack observed=%h expected=no_ack", conDATA);
      end else begin
        v = exp_q.pop_front();
        assert (conDATA === v) else begin
          n_err++;
          $error("FAIL ack_data observed=%h expected=%h", conDATA, v);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; cromDBUS_SEL = SEL_DP; forceRAMFILE = 1'b0; cpuHALT = 1'b0;
    conREQ = 1'b0; conSEL = SEL_FLAGS; dbus = '0;

    // Reset state, select follows the microcode request combinationally
    #2;
    chk("rst_ack", 36'(conACK), 36'd0);
    chk("rst_data", conDATA, 36'd0);
    chk("rst_wait", 36'(cpuWAIT), 36'd0);
    chk("rst_sel_dp", 36'(dbusSEL), 36'(SEL_DP));
    cromDBUS_SEL = SEL_RAM;
    #1;
    chk("rst_sel_ram", 36'(dbusSEL), 36'(SEL_RAM));
    chk("rst_wait_ram", 36'(cpuWAIT), 36'd0);
    cromDBUS_SEL = SEL_DP;
    #20 rst_n = 1'b1;
    tick();

    // DP then RAM for three cycles: wait only on the first RAM cycle
    chk_out("dp", SEL_DP, 1'b0, 1'b0); tick();
    cromDBUS_SEL = SEL_RAM;
    chk_out("ram1", SEL_RAM, 1'b1, 1'b0); tick();
    chk_out("ram2", SEL_RAM, 1'b0, 1'b0); tick();
    chk_out("ram3", SEL_RAM, 1'b0, 1'b0); tick();
    cromDBUS_SEL = SEL_DP;
    chk_out("dp2", SEL_DP, 1'b0, 1'b0); tick();

    // DBM forced to the ramfile
    cromDBUS_SEL = SEL_DBM; forceRAMFILE = 1'b1;
    chk_out("dbmf1", SEL_RAM, 1'b1, 1'b0); tick();
    chk_out("dbmf2", SEL_RAM, 1'b0, 1'b0); tick();
    forceRAMFILE = 1'b0;
    chk_out("dbm", SEL_DBM, 1'b0, 1'b0); tick();
    cromDBUS_SEL = SEL_DP;
    tick();

    // Console read of FLAGS: ack three cycles after the request sample
    cpuHALT = 1'b1; conREQ = 1'b1; conSEL = SEL_FLAGS; dbus = 36'o123456701234;
    exp_q.push_back(36'o123456701234);
    chk_out("cf_idle", SEL_DP, 1'b0, 1'b0); tick();
    chk_out("cf_sel", SEL_FLAGS, 1'b1, 1'b0); tick();
    chk_out("cf_cap", SEL_FLAGS, 1'b1, 1'b0); tick();
    chk_out("cf_ack", SEL_DP, 1'b0, 1'b1);
    chk("cf_data", conDATA, 36'o123456701234);
    tick();
    chk_out("cf_after", SEL_DP, 1'b0, 1'b0);
    chk("cf_hold", conDATA, 36'o123456701234);
    conREQ = 1'b0; tick();

    // Console read of RAM: four cycles, halt dropping mid-sequence does not abort
    conREQ = 1'b1; conSEL = SEL_RAM; dbus = 36'h9_8765_4321;
    exp_q.push_back(36'h9_8765_4321);
    chk_out("cr_idle", SEL_DP, 1'b0, 1'b0); tick();
    cpuHALT = 1'b0;
    chk_out("cr_sel", SEL_RAM, 1'b1, 1'b0); tick();
    chk_out("cr_ram", SEL_RAM, 1'b1, 1'b0); tick();
    chk_out("cr_cap", SEL_RAM, 1'b1, 1'b0); tick();
    chk_out("cr_ack", SEL_DP, 1'b0, 1'b1); tick();
    conREQ = 1'b0; cpuHALT = 1'b1; tick();

    // Held request acks once; re-assertion acks again
    ack_base = n_ack;
    conSEL = SEL_DP; dbus = 36'(64'($urandom) << 4) ^ 36'h5;
    exp_q.push_back(dbus);
    conREQ = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    settle();
    chk("held_acks", 36'(n_ack - ack_base), 36'd1);
    tick();
    conREQ = 1'b0; tick();
    dbus = 36'h0_ABCD_EF01;
    exp_q.push_back(36'h0_ABCD_EF01);
    conREQ = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    settle();
    chk("rearm_acks", 36'(n_ack - ack_base), 36'd2);
    tick();
    conREQ = 1'b0; tick();

    // Console request together with a DP->RAM switch: RAM wait wins
    dbus = 36'h3_1415_9265;
    cromDBUS_SEL = SEL_RAM; conREQ = 1'b1; conSEL = SEL_FLAGS;
    exp_q.push_back(36'h3_1415_9265);
    chk_out("mix_w", SEL_RAM, 1'b1, 1'b0); tick();
    chk_out("mix_rw", SEL_RAM, 1'b0, 1'b0); tick();
    chk_out("mix_id", SEL_RAM, 1'b0, 1'b0); tick();
    chk_out("mix_sel", SEL_FLAGS, 1'b1, 1'b0); tick();
    chk_out("mix_cap", SEL_FLAGS, 1'b1, 1'b0); tick();
    cromDBUS_SEL = SEL_DP;
    chk_out("mix_ack", SEL_DP, 1'b0, 1'b1); tick();
    conREQ = 1'b0; tick();

    // Reset during CONRAM discards the access
    conREQ = 1'b1; conSEL = SEL_RAM; dbus = 36'h7_7777_0000;
    tick();
    tick();
    chk_out("rr_ram", SEL_RAM, 1'b1, 1'b0);
    rst_n = 1'b0; conREQ = 1'b0;
    #1;
    chk("rr_ack", 36'(conACK), 36'd0);
    chk("rr_data", conDATA, 36'd0);
    chk("rr_state", 36'(dut.state), 36'(IDLE));
    chk("rr_wait", 36'(cpuWAIT), 36'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    ack_base = n_ack;
    for (int i = 0; i < 6; i++) tick();
    settle();
    chk("rr_noack", 36'(n_ack - ack_base), 36'd0);
    chk("rr_data2", conDATA, 36'd0);
    chk("queue_empty", 36'(exp_q.size()), 36'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
